// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// muldiv_unit_pkg : MD_OP codes and FSM state encodings for muldiv_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   // Ops that go through the iterative datapath.
   function automatic logic op_is_iter(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_iter_core.sv
// ============================================================================
// md_iter_core : radix-2 shift-add multiply / restoring divide on magnitudes
// Rev 1.0
// ============================================================================
`default_nettype none

module md_iter_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] sr,
   output logic             last
);

   logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, bop_q, bop_d, addend;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   sum, rem_sh, diff;

   // Multiply: {acc,sr} is the product shifting right; divide: acc is the
   // partial remainder, sr shifts dividend bits out and quotient bits in.
   always_comb begin
      addend = sr_q[0] ? bop_q : '0;
      sum    = {1'b0, acc_q} + {1'b0, addend};
      rem_sh = {acc_q, sr_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, bop_q};
      acc_d  = acc_q;
      sr_d   = sr_q;
      bop_d  = bop_q;
      cnt_d  = cnt_q;
      if (load) begin
         acc_d = '0;
         sr_d  = a_in;
         bop_d = b_in;
         cnt_d = '0;
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div) begin
            if (!diff[WIDTH]) begin
               acc_d = diff[WIDTH-1:0];
               sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = sum[WIDTH:1];
            sr_d  = {sum[0], sr_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         sr_q  <= '0;
         bop_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         sr_q  <= sr_d;
         bop_q <= bop_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc  = acc_q;
   assign sr   = sr_q;
   assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : multi-cycle MULT/DIV unit with architectural HI/LO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [1:0]         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d, done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               core_load, core_step, core_last, core_div;
   logic               signed_op, div_op, dz;
   logic [WIDTH-1:0]   a_mag, b_mag, core_acc, core_sr, q_fix, r_fix;
   logic [2*WIDTH-1:0] prod, prod_fix;

   md_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (core_load),
      .step   (core_step),
      .is_div (core_div),
      .a_in   (a_mag),
      .b_in   (b_mag),
      .acc    (core_acc),
      .sr     (core_sr),
      .last   (core_last)
   );

   always_comb begin
      div_op    = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
      signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
      dz        = div_op && (b == '0);
      // Divide-by-zero keeps the raw dividend so it can be returned in HI.
      a_mag     = (signed_op && a[WIDTH-1] && !dz) ? -a : a;
      b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
      core_div  = (op_q == MD_OP_DIV) || (op_q == MD_OP_DIVU);
      prod      = {core_acc, core_sr};
      prod_fix  = neg_res_q ? -prod : prod;
      q_fix     = neg_res_q ? -core_sr : core_sr;
      r_fix     = neg_rem_q ? -core_acc : core_acc;

      state_d   = state_q;
      op_d      = op_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               if (op_is_iter(op)) begin
                  core_load = 1'b1;
                  op_d      = op;
                  neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_d = signed_op && a[WIDTH-1];
                  dz_d      = dz;
                  state_d   = dz ? FIX : RUN;
               end else if (op == MD_OP_MTHI) begin
                  hi_d = a;
               end else if (op == MD_OP_MTLO) begin
                  lo_d = a;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               core_step = 1'b1;
               if (core_last) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (dz_q) begin
                  hi_d = core_sr;
                  lo_d = '1;
               end else if (core_div) begin
                  hi_d = r_fix;
                  lo_d = q_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= MD_OP_MULT;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vectors with a scoreboard queue and done monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op_i = 3'd0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         flush = 1'b0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [63:0]  exp_q[$];
   logic [63:0]  exp_v;
   logic [W-1:0] hi_sv, lo_sv;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op_i),
      .a     (a_i),
      .b     (b_i),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_cmp++;
         if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_during_done: got %b expected 0", busy);
         end
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
         end else begin
            exp_v = exp_q.pop_front();
            if ({hi, lo} !== exp_v) begin
               n_err++;
               $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h",
                        hi, lo, exp_v[63:32], exp_v[31:0]);
            end
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input int ebusy, input bit poke);
      int cnt;
      @(negedge clk);
      start = 1'b1; op_i = op; a_i = a; b_i = b;
      exp_q.push_back({ehi, elo});
      @(posedge clk); #1;
      start = 1'b0;
      a_i = 32'h5A5A_A5A5; b_i = 32'h0000_0003;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         if (poke && cnt == 10) begin
            start = 1'b1; op_i = MD_OP_MTHI; a_i = 32'hDEAD_BEEF;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cnt++;
      end
      check({name, "_busy_cycles"}, 64'(cnt), 64'(ebusy));
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue("mult_neg", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b1);
      issue("multu", MD_OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 33, 1'b0);
      issue("divu", MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
      issue("div_negdvd", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
      issue("div_negdvs", MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 1'b0);
      issue("div_zero", MD_OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b0);
      issue("div_zero_neg", MD_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 1'b0);
      issue("div_ovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b0);
      issue("mult_m1m1", MD_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 33, 1'b0);
      issue("multu_max", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);

      // Flush mid-RUN, with ignored MTHI and second start along the way.
      hi_sv = hi; lo_sv = lo;
      @(negedge clk);
      start = 1'b1; op_i = MD_OP_MULT; a_i = 32'd7; b_i = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; op_i = MD_OP_MTHI; a_i = 32'hDEAD_0000;
      @(posedge clk); #1;
      op_i = MD_OP_MULT; a_i = 32'd1; b_i = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check("mthi_while_busy", {31'd0, busy, hi}, {31'd0, 1'b1, hi_sv});
      repeat (8) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_idle", {31'd0, busy, 32'd0}, 64'd0);
      check("flush_hilo", {hi, lo}, {hi_sv, lo_sv});
      repeat (40) @(posedge clk);
      #1;
      check("flush_no_restart", {31'd0, busy, hi}, {32'd0, hi_sv});

      // Flush in IDLE drops a simultaneous start.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op_i = MD_OP_MULTU; a_i = 32'd3; b_i = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_drops_start", {31'd0, busy, 32'd0}, 64'd0);
      repeat (40) @(posedge clk);

      // Reserved op code.
      @(negedge clk);
      start = 1'b1; op_i = 3'd6; a_i = 32'h7777_7777; b_i = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      check("reserved_op", {hi, lo}, {hi_sv, lo_sv});
      check("reserved_busy", {62'd0, busy, done}, 64'd0);

      // MTHI / MTLO.
      @(negedge clk);
      start = 1'b1; op_i = MD_OP_MTHI; a_i = 32'hABCD_0001;
      @(posedge clk); #1;
      start = 1'b0;
      check("mthi", {hi, lo}, {32'hABCD_0001, lo_sv});
      @(negedge clk);
      start = 1'b1; op_i = MD_OP_MTLO; a_i = 32'h0000_1234;
      @(posedge clk); #1;
      start = 1'b0;
      check("mtlo", {hi, lo}, {32'hABCD_0001, 32'h0000_1234});
      check("mtlo_flags", {62'd0, busy, done}, 64'd0);
      @(posedge clk); #1;
      check("mtlo_no_done", {62'd0, busy, done}, 64'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      start = 1'b1; op_i = MD_OP_DIVU; a_i = 32'd1000; b_i = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {hi, lo}, 64'd0);
      check("async_reset_flags", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);

      issue("post_reset_divu", MD_OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 1'b0);

      repeat (5) @(posedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, for the EX stage of the pipelined MIPS core.
- It sits beside the single-cycle ALU and covers MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- HI/LO feed MFHI/MFLO directly.
- `busy` stalls the pipeline while an iterative operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk    in   1      rising-edge clock.
- rst_n  in   1      asynchronous active-low reset.
- start  in   1      issue request, sampled on clk; accepted only when busy=0.
- op     in   3      MD_OP code; valid with start.
- a      in   WIDTH  rs operand; dividend / multiplicand / MTHI-MTLO source.
- b      in   WIDTH  rt operand; divisor / multiplier.
- flush  in   1      abort in-flight operation (exception/branch squash).
- busy   out  1      high while an iterative op is in progress; pipeline stall.
- done   out  1      one-cycle pulse on the cycle HI/LO hold a new mul/div result.
- hi     out  WIDTH  HI register.
- lo     out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. This also applies mid-operation; any partial result is discarded.
- States:
  - IDLE: start with MULT/MULTU/DIV/DIVU → RUN. MTHI/MTLO → write and stay in IDLE.
  - RUN: one radix-2 iteration per edge. After WIDTH iterations → FIX.
  - FIX: sign correction, write HI/LO, done=1 → IDLE.
- Latency: start accepted at edge 0; done is high, with HI/LO updated, in the cycle after edge WIDTH+1. busy is high for exactly WIDTH+1 cycles and is low while done is high.
- MULT/MULTU:
  - Shift-add on magnitudes; the 2·WIDTH product is formed in {hi,lo}.
  - Signed: operands are negated if negative at edge 0; the product is negated in FIX when sign(a)^sign(b).
- DIV/DIVU:
  - Restoring division on magnitudes. lo=quotient, hi=remainder.
  - Signed: quotient sign is sign(a)^sign(b); remainder sign follows the dividend (truncating division).
- Divide by zero (b=0, DIV or DIVU): no RUN phase. IDLE → FIX directly, lo={WIDTH{1}}, hi=a, done at the cycle after edge 1, busy high 1 cycle.
- Signed overflow (a=most-negative, b=-1): lo=most-negative, hi=0. This is the natural result of magnitude arithmetic truncated to WIDTH, with no trap.
- MTHI/MTLO:
  - Written on the accepting edge; busy stays 0 and no done pulse.
  - MTHI leaves lo unchanged; MTLO leaves hi unchanged.
- op codes 6/7 are reserved: ignored, with no state change.
- start while busy=1 is ignored; the operation in progress is unaffected. The pipeline must hold the instruction.
- flush:
  - In RUN or FIX: the next edge returns to IDLE, hi/lo keep their pre-operation values, and no done is raised.
  - In IDLE: a simultaneous start is dropped (flush wins).
- Operands are captured at edge 0. Changes on a/b/op during RUN have no effect.
- hi/lo only change on a FIX write, MTHI/MTLO, or reset. Partial products and remainders live in internal shadow registers, so HI/LO are stable during RUN.

Decomposition:
- Shared define header (alongside the existing func/ALU op defines) holds MD_OP_MULT=0, MD_OP_MULTU=1, MD_OP_DIV=2, MD_OP_DIVU=3, MD_OP_MTHI=4, MD_OP_MTLO=5, and the state encodings IDLE/RUN/FIX.
- One sub-module, md_iter_core, holds the WIDTH-iteration shift-add/restoring-divide datapath (acc, quotient/multiplier shift register, counter).
- The top level keeps the FSM, sign handling, flush and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → busy for 33 cycles, then done pulse: hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 → busy 1 cycle, done next cycle: lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULT, then at cycle 10 assert MTHI and a second start → both ignored. At cycle 20 assert flush → IDLE next edge, no done, hi/lo unchanged.
- MTLO a=0x1234 in IDLE → lo=0x1234 next edge, hi unchanged, busy/done stay 0. Drop rst_n mid-DIV → hi=lo=0, busy=0 immediately, without waiting for a clock edge.
